// File: rtl/trivium_pkg.sv
// Shared constants, tap positions and FSM state type for the Trivium stream core.
// Tap constants use Trivium's 1-based numbering; bit s(i) lives at vector index i-1.
package trivium_pkg;

    localparam int STATE_W      = 288;
    localparam int KEY_W        = 80;
    localparam int IV_W         = 80;
    localparam int WARMUP_STEPS = 1152;
    localparam int IV_OFS       = 93;

    localparam int T1_A   = 66;
    localparam int T1_B   = 93;
    localparam int T1_AA  = 91;
    localparam int T1_AB  = 92;
    localparam int T1_C   = 171;
    localparam int T2_A   = 162;
    localparam int T2_B   = 177;
    localparam int T2_AA  = 175;
    localparam int T2_AB  = 176;
    localparam int T2_C   = 264;
    localparam int T3_A   = 243;
    localparam int T3_B   = 288;
    localparam int T3_AA  = 286;
    localparam int T3_AB  = 287;
    localparam int T3_C   = 69;
    localparam int T1_IN  = 94;
    localparam int T2_IN  = 178;
    localparam int T3_IN  = 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_WARM = 2'd2,
        ST_RUN  = 2'd3
    } core_state_e;

    // Initial register image: key in s1..s80, IV in s94..s173, ones in s286..s288.
    function automatic logic [STATE_W-1:0] load_state(input logic [KEY_W-1:0] key,
                                                      input logic [IV_W-1:0]  iv);
        logic [STATE_W-1:0] s;
        s                   = {STATE_W{1'b0}};
        s[KEY_W-1:0]        = key;
        s[IV_OFS +: IV_W]   = iv;
        s[STATE_W-1 -: 3]   = 3'b111;
        return s;
    endfunction

endpackage

// File: rtl/trivium_step.sv
// One combinational Trivium clocking step: 288-bit state in, updated state and keystream bit out.
module trivium_step
    import trivium_pkg::*;
(
    input  logic [STATE_W-1:0] s_in,
    output logic [STATE_W-1:0] s_out,
    output logic               z
);

    logic t1_s;
    logic t2_s;
    logic t3_s;

    // Keystream bit comes from the linear taps only; nonlinear terms feed back.
    always_comb begin
        t1_s  = s_in[T1_A-1] ^ s_in[T1_B-1];
        t2_s  = s_in[T2_A-1] ^ s_in[T2_B-1];
        t3_s  = s_in[T3_A-1] ^ s_in[T3_B-1];
        z     = t1_s ^ t2_s ^ t3_s;
        t1_s  = t1_s ^ (s_in[T1_AA-1] & s_in[T1_AB-1]) ^ s_in[T1_C-1];
        t2_s  = t2_s ^ (s_in[T2_AA-1] & s_in[T2_AB-1]) ^ s_in[T2_C-1];
        t3_s  = t3_s ^ (s_in[T3_AA-1] & s_in[T3_AB-1]) ^ s_in[T3_C-1];
        s_out = {s_in[STATE_W-2:0], 1'b0};
        s_out[T3_IN-1] = t3_s;
        s_out[T1_IN-1] = t1_s;
        s_out[T2_IN-1] = t2_s;
    end

endmodule

// File: rtl/trivium_stream_core.sv
// Trivium keystream core: W steps per cycle, init/warm-up FSM and a one-deep registered output.
module trivium_stream_core
    import trivium_pkg::*;
#(
    parameter int W      = 8,
    parameter bit XOR_EN = 1'b1
)
(
    input  logic               clk,
    input  logic               rst,
    input  logic [KEY_W-1:0]   key_in,
    input  logic [IV_W-1:0]    iv_in,
    input  logic               init_valid,
    output logic               init_ready,
    input  logic [W-1:0]       din,
    input  logic               din_valid,
    output logic               din_ready,
    output logic [W-1:0]       dout,
    output logic               dout_valid,
    input  logic               dout_ready,
    output logic               busy
);

    localparam int WARM_CYCLES = WARMUP_STEPS / W;
    localparam int CNT_W       = $clog2(WARM_CYCLES + 1);

    core_state_e        state_r;
    core_state_e        state_nxt_s;
    logic [STATE_W-1:0] s_r;
    logic [STATE_W-1:0] s_nxt_s;
    logic [CNT_W-1:0]   cnt_r;
    logic [CNT_W-1:0]   cnt_nxt_s;
    logic [W-1:0]       dout_r;
    logic               dout_valid_r;
    logic [W-1:0]       ks_s;
    logic [W-1:0]       word_s;
    logic               run_s;
    logic               din_accept_s;
    logic [STATE_W-1:0] chain_s [0:W];

    assign chain_s[0] = s_r;

    for (genvar g = 0; g < W; g++) begin : g_step
        trivium_step u_step (
            .s_in  (chain_s[g]),
            .s_out (chain_s[g+1]),
            .z     (ks_s[g])
        );
    end

    assign init_ready   = 1'b1;
    assign din_accept_s = din_valid & din_ready;
    assign dout         = dout_r;
    assign dout_valid   = dout_valid_r;

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next state: init restarts from any state and wins over everything else.
    always_comb begin
        state_nxt_s = state_r;
        if (init_valid) begin
            state_nxt_s = ST_LOAD;
        end else begin
            case (state_r)
                ST_IDLE: state_nxt_s = ST_IDLE;
                ST_LOAD: state_nxt_s = ST_WARM;
                ST_WARM: begin
                    if (cnt_r <= CNT_W'(1)) begin
                        state_nxt_s = ST_RUN;
                    end else begin
                        state_nxt_s = ST_WARM;
                    end
                end
                ST_RUN:  state_nxt_s = ST_RUN;
                default: state_nxt_s = ST_IDLE;
            endcase
        end
    end

    // FSM outputs; a same-cycle init blocks data acceptance.
    always_comb begin
        busy  = 1'b0;
        run_s = 1'b0;
        case (state_r)
            ST_LOAD: busy  = 1'b1;
            ST_WARM: busy  = 1'b1;
            ST_RUN:  run_s = 1'b1;
            default: run_s = 1'b0;
        endcase
        din_ready = run_s & (~dout_valid_r | dout_ready) & ~init_valid;
    end

    // Cipher state and warm-up counter next values; the state only moves in WARM or on accept.
    always_comb begin
        s_nxt_s   = s_r;
        cnt_nxt_s = cnt_r;
        if (init_valid) begin
            s_nxt_s = load_state(key_in, iv_in);
        end else if (state_r == ST_LOAD) begin
            cnt_nxt_s = CNT_W'(WARM_CYCLES);
        end else if (state_r == ST_WARM) begin
            s_nxt_s = chain_s[W];
            if (cnt_r != {CNT_W{1'b0}}) begin
                cnt_nxt_s = cnt_r - CNT_W'(1);
            end else begin
                cnt_nxt_s = cnt_r;
            end
        end else if (din_accept_s) begin
            s_nxt_s = chain_s[W];
        end else begin
            s_nxt_s = s_r;
        end
    end

    // Cipher state and counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_r   <= {STATE_W{1'b0}};
            cnt_r <= {CNT_W{1'b0}};
        end else begin
            s_r   <= s_nxt_s;
            cnt_r <= cnt_nxt_s;
        end
    end

    // Output word selection.
    always_comb begin
        if (XOR_EN) begin
            word_s = din ^ ks_s;
        end else begin
            word_s = ks_s;
        end
    end

    // Output holding register: init discards, accept loads, drain empties.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout_r       <= {W{1'b0}};
            dout_valid_r <= 1'b0;
        end else if (init_valid) begin
            dout_valid_r <= 1'b0;
        end else if (din_accept_s) begin
            dout_r       <= word_s;
            dout_valid_r <= 1'b1;
        end else if (dout_ready) begin
            dout_valid_r <= 1'b0;
        end
    end

endmodule

// File: tb/tb_trivium_stream_core.sv
// Scoreboard bench: four core instances (W=8 raw, W=8 XOR, W=1 raw, W=64 raw) checked against a Trivium model.
module tb_trivium_stream_core;

    logic        clk = 1'b0;
    logic        rst;
    logic [79:0] key_in;
    logic [79:0] iv_in;
    logic        init_valid;

    logic [7:0]  din_a, dout_a, din_b, dout_b;
    logic [0:0]  din_c, dout_c;
    logic [63:0] din_d, dout_d;
    logic din_valid_a, din_ready_a, dout_valid_a, dout_ready_a, busy_a, init_ready_a;
    logic din_valid_b, din_ready_b, dout_valid_b, dout_ready_b, busy_b, init_ready_b;
    logic din_valid_c, din_ready_c, dout_valid_c, dout_ready_c, busy_c, init_ready_c;
    logic din_valid_d, din_ready_d, dout_valid_d, dout_ready_d, busy_d, init_ready_d;

    logic [63:0] q_a[$], q_b[$], q_c[$], q_d[$];
    logic [7:0]  ct_q[$];
    bit          ks_bits[$];
    int          acc_a, acc_b, acc_c, acc_d;
    int          ptr_a, ptr_b, ptr_c, ptr_d;
    bit          rec_ct, b_rt, b_stall_prev;
    logic [7:0]  b_prev;
    int          n_checks = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    trivium_stream_core #(.W(8), .XOR_EN(1'b0)) u_a (
        .clk(clk), .rst(rst), .key_in(key_in), .iv_in(iv_in), .init_valid(init_valid),
        .init_ready(init_ready_a), .din(din_a), .din_valid(din_valid_a), .din_ready(din_ready_a),
        .dout(dout_a), .dout_valid(dout_valid_a), .dout_ready(dout_ready_a), .busy(busy_a));
    trivium_stream_core #(.W(8), .XOR_EN(1'b1)) u_b (
        .clk(clk), .rst(rst), .key_in(key_in), .iv_in(iv_in), .init_valid(init_valid),
        .init_ready(init_ready_b), .din(din_b), .din_valid(din_valid_b), .din_ready(din_ready_b),
        .dout(dout_b), .dout_valid(dout_valid_b), .dout_ready(dout_ready_b), .busy(busy_b));
    trivium_stream_core #(.W(1), .XOR_EN(1'b0)) u_c (
        .clk(clk), .rst(rst), .key_in(key_in), .iv_in(iv_in), .init_valid(init_valid),
        .init_ready(init_ready_c), .din(din_c), .din_valid(din_valid_c), .din_ready(din_ready_c),
        .dout(dout_c), .dout_valid(dout_valid_c), .dout_ready(dout_ready_c), .busy(busy_c));
    trivium_stream_core #(.W(64), .XOR_EN(1'b0)) u_d (
        .clk(clk), .rst(rst), .key_in(key_in), .iv_in(iv_in), .init_valid(init_valid),
        .init_ready(init_ready_d), .din(din_d), .din_valid(din_valid_d), .din_ready(din_ready_d),
        .dout(dout_d), .dout_valid(dout_valid_d), .dout_ready(dout_ready_d), .busy(busy_d));

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference Trivium written straight from the step equations on a 1-based bit array.
    task automatic model_gen(input logic [79:0] k, input logic [79:0] v, input int nbits);
        bit ms [1:288];
        bit t1, t2, t3, z;
        for (int i = 1; i <= 288; i++) ms[i] = 1'b0;
        for (int i = 1; i <= 80; i++) begin
            ms[i]      = k[i-1];
            ms[93 + i] = v[i-1];
        end
        ms[286] = 1'b1; ms[287] = 1'b1; ms[288] = 1'b1;
        ks_bits.delete();
        for (int n = 0; n < 1152 + nbits; n++) begin
            t1 = ms[66] ^ ms[93];
            t2 = ms[162] ^ ms[177];
            t3 = ms[243] ^ ms[288];
            z  = t1 ^ t2 ^ t3;
            t1 = t1 ^ (ms[91] & ms[92]) ^ ms[171];
            t2 = t2 ^ (ms[175] & ms[176]) ^ ms[264];
            t3 = t3 ^ (ms[286] & ms[287]) ^ ms[69];
            for (int i = 288; i > 1; i--) ms[i] = ms[i-1];
            ms[1] = t3; ms[94] = t1; ms[178] = t2;
            if (n >= 1152) ks_bits.push_back(z);
        end
    endtask

    function automatic logic [63:0] ks_word(input int ptr, input int w);
        logic [63:0] r;
        r = 64'd0;
        for (int k = 0; k < w; k++) begin
            if (ptr + k < ks_bits.size()) r[k] = ks_bits[ptr + k];
        end
        return r;
    endfunction

    // Scoreboard: push expected words on accept, pop and compare on transfer.
    always @(negedge clk) begin
        if (rst || init_valid) begin
            q_a.delete(); q_b.delete(); q_c.delete(); q_d.delete();
            acc_a = 0; acc_b = 0; acc_c = 0; acc_d = 0;
            ptr_a = 0; ptr_b = 0; ptr_c = 0; ptr_d = 0;
            b_stall_prev = 1'b0;
        end else begin
            if (din_valid_a && din_ready_a) begin q_a.push_back(ks_word(ptr_a, 8)); ptr_a += 8; acc_a++; end
            if (dout_valid_a && dout_ready_a) begin
                if (q_a.size() == 0) check_eq("a_spurious", {63'd0, dout_valid_a}, 64'd0);
                else check_eq("a_word", {56'd0, dout_a}, q_a.pop_front());
            end
            if (din_valid_c && din_ready_c) begin q_c.push_back(ks_word(ptr_c, 1)); ptr_c += 1; acc_c++; end
            if (dout_valid_c && dout_ready_c) begin
                if (q_c.size() == 0) check_eq("c_spurious", {63'd0, dout_valid_c}, 64'd0);
                else check_eq("c_word", {63'd0, dout_c}, q_c.pop_front());
            end
            if (din_valid_d && din_ready_d) begin q_d.push_back(ks_word(ptr_d, 64)); ptr_d += 64; acc_d++; end
            if (dout_valid_d && dout_ready_d) begin
                if (q_d.size() == 0) check_eq("d_spurious", {63'd0, dout_valid_d}, 64'd0);
                else check_eq("d_word", dout_d, q_d.pop_front());
            end
            if (b_stall_prev) begin
                check_eq("b_hold_valid", {63'd0, dout_valid_b}, 64'd1);
                check_eq("b_hold_data", {56'd0, dout_b}, {56'd0, b_prev});
            end
            if (din_valid_b && din_ready_b) begin
                if (b_rt) q_b.push_back(64'h00000000000000A5);
                else      q_b.push_back({56'd0, din_b} ^ ks_word(ptr_b, 8));
                ptr_b += 8; acc_b++;
            end
            if (dout_valid_b && dout_ready_b) begin
                if (q_b.size() == 0) check_eq("b_spurious", {63'd0, dout_valid_b}, 64'd0);
                else check_eq("b_word", {56'd0, dout_b}, q_b.pop_front());
                if (rec_ct) ct_q.push_back(dout_b);
            end
            b_stall_prev = dout_valid_b && !dout_ready_b;
            b_prev       = dout_b;
        end
    end

    task automatic check_idle(input string tag);
        check_eq({tag, "_busy"},   {60'd0, busy_a, busy_b, busy_c, busy_d}, 64'd0);
        check_eq({tag, "_ready"},  {60'd0, din_ready_a, din_ready_b, din_ready_c, din_ready_d}, 64'd0);
        check_eq({tag, "_valid"},  {60'd0, dout_valid_a, dout_valid_b, dout_valid_c, dout_valid_d}, 64'd0);
        check_eq({tag, "_iready"}, {60'd0, init_ready_a, init_ready_b, init_ready_c, init_ready_d}, 64'hF);
        check_eq({tag, "_dout_abc"}, {47'd0, dout_a, dout_b, dout_c}, 64'd0);
        check_eq({tag, "_dout_d"}, dout_d, 64'd0);
    endtask

    task automatic do_init(input logic [79:0] k, input logic [79:0] v);
        @(posedge clk); #1;
        key_in = k; iv_in = v; init_valid = 1'b1;
        din_valid_a = 1'b0; din_valid_b = 1'b0; din_valid_c = 1'b0; din_valid_d = 1'b0;
        dout_ready_b = 1'b0;
        model_gen(k, v, 4096);
        @(posedge clk); #1;
        init_valid = 1'b0;
    endtask

    task automatic run_words(input int lim, input bit chk_busy);
        int nb_a, nb_c, nb_d, cyc;
        bit done;
        nb_a = 0; nb_c = 0; nb_d = 0; cyc = 0; done = 1'b0;
        while (!done && cyc < 4000) begin
            nb_a += int'(busy_a); nb_c += int'(busy_c); nb_d += int'(busy_d);
            din_valid_a = (acc_a < lim); din_valid_c = (acc_c < lim);
            din_valid_d = (acc_d < lim); din_valid_b = (acc_b < lim);
            if (b_rt && acc_b < ct_q.size()) din_b = ct_q[acc_b];
            else din_b = 8'hA5;
            dout_ready_b = ($urandom_range(0, 1) == 1);
            @(posedge clk); #1;
            cyc++;
            done = (acc_a >= lim) && (acc_b >= lim) && (acc_c >= lim) && (acc_d >= lim) &&
                   (q_a.size() == 0) && (q_b.size() == 0) && (q_c.size() == 0) && (q_d.size() == 0) &&
                   !dout_valid_a && !dout_valid_b && !dout_valid_c && !dout_valid_d;
        end
        din_valid_a = 1'b0; din_valid_b = 1'b0; din_valid_c = 1'b0; din_valid_d = 1'b0;
        dout_ready_b = 1'b0;
        check_eq("run_done", {63'd0, done}, 64'd1);
        if (chk_busy) begin
            check_eq("busy_cycles_w8", 64'(nb_a), 64'd145);
            check_eq("busy_cycles_w1", 64'(nb_c), 64'd1153);
            check_eq("busy_cycles_w64", 64'(nb_d), 64'd19);
            check_eq("run_din_ready_w8", {63'd0, din_ready_a}, 64'd1);
        end
    endtask

    initial begin
        rst = 1'b1; init_valid = 1'b0; key_in = 80'd0; iv_in = 80'd0;
        din_a = 8'd0; din_b = 8'd0; din_c = 1'b0; din_d = 64'd0;
        din_valid_a = 1'b0; din_valid_b = 1'b0; din_valid_c = 1'b0; din_valid_d = 1'b0;
        dout_ready_a = 1'b1; dout_ready_b = 1'b0; dout_ready_c = 1'b1; dout_ready_d = 1'b1;
        rec_ct = 1'b0; b_rt = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_idle("reset");
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_idle("idle");

        do_init(80'd0, 80'd0);
        run_words(64, 1'b1);

        ct_q.delete(); rec_ct = 1'b1;
        do_init(80'h0123456789ABCDEF0F1E, 80'hFEDCBA98765432100A5C);
        run_words(64, 1'b0);
        rec_ct = 1'b0;
        check_eq("ct_count", 64'(ct_q.size()), 64'd64);

        b_rt = 1'b1;
        do_init(80'h0123456789ABCDEF0F1E, 80'hFEDCBA98765432100A5C);
        run_words(64, 1'b0);
        b_rt = 1'b0;

        // Stall a held word, then re-init over it.
        din_b = 8'h3C; din_valid_b = 1'b1; dout_ready_b = 1'b0;
        @(posedge clk); #1;
        din_valid_b = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("stall_valid", {63'd0, dout_valid_b}, 64'd1);
        do_init(80'hA5A5_5A5A_0F0F_F0F0_1234, 80'h8000_0000_0000_0000_0001);
        check_eq("init_drops_valid", {63'd0, dout_valid_b}, 64'd0);
        check_eq("init_busy", {63'd0, busy_b}, 64'd1);
        run_words(16, 1'b0);

        // Reset in the middle of warm-up.
        do_init(80'h1111_2222_3333_4444_5555, 80'h0000_0000_0000_0000_0080);
        repeat (10) @(posedge clk);
        #1;
        check_eq("warm_busy", {60'd0, busy_a, busy_b, busy_c, busy_d}, 64'hF);
        rst = 1'b1;
        #1;
        check_idle("rst_async");
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check_idle("post_rst");
        do_init(80'h1111_2222_3333_4444_5555, 80'h0000_0000_0000_0000_0080);
        run_words(16, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
